// File: rtl/c64_keymatrix.sv
// c64_keymatrix: USB HID key events -> C64 8x8 keyboard matrix image with
// CIA1 scan answers in both directions, a RESTORE line and a virtual SHIFT
// for cursor-up/left.
// Optional: define KBD_SHIFTLOCK_EN to make CapsLock toggle a shift-lock
// that holds LSHIFT down.
module c64_keymatrix #(
    parameter int SCAN_REG = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] usb_kbd,
    input  logic [7:0] pa_out,
    input  logic [7:0] pb_out,
    output logic [7:0] pb_in,
    output logic [7:0] pa_in,
    output logic       restore,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DECODE, APPLY} state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] col;
        logic [2:0] row;
        logic       vup;
        logic       vleft;
        logic       rst;
`ifdef KBD_SHIFTLOCK_EN
        logic       lock;
`endif
    } key_t;

    // Matrix position helper for the keymap table
    function automatic key_t pos(input logic [2:0] c, input logic [2:0] r);
        key_t k;
        k     = '0;
        k.hit = 1'b1;
        k.col = c;
        k.row = r;
        return k;
    endfunction

    // USB usage code -> C64 matrix position (col = PA bit, row = PB bit)
    function automatic key_t lookup(input logic [6:0] code);
        key_t k;
        k = '0;
        case (code)
            7'h04: k = pos(3'd1, 3'd2);  // A
            7'h05: k = pos(3'd3, 3'd4);  // B
            7'h06: k = pos(3'd2, 3'd4);  // C
            7'h07: k = pos(3'd2, 3'd2);  // D
            7'h08: k = pos(3'd1, 3'd6);  // E
            7'h09: k = pos(3'd2, 3'd5);  // F
            7'h0A: k = pos(3'd3, 3'd2);  // G
            7'h0B: k = pos(3'd3, 3'd5);  // H
            7'h0C: k = pos(3'd4, 3'd1);  // I
            7'h0D: k = pos(3'd4, 3'd2);  // J
            7'h0E: k = pos(3'd4, 3'd5);  // K
            7'h0F: k = pos(3'd5, 3'd2);  // L
            7'h10: k = pos(3'd4, 3'd4);  // M
            7'h11: k = pos(3'd4, 3'd7);  // N
            7'h12: k = pos(3'd4, 3'd6);  // O
            7'h13: k = pos(3'd5, 3'd1);  // P
            7'h14: k = pos(3'd7, 3'd6);  // Q
            7'h15: k = pos(3'd2, 3'd1);  // R
            7'h16: k = pos(3'd1, 3'd5);  // S
            7'h17: k = pos(3'd2, 3'd6);  // T
            7'h18: k = pos(3'd3, 3'd6);  // U
            7'h19: k = pos(3'd3, 3'd7);  // V
            7'h1A: k = pos(3'd1, 3'd1);  // W
            7'h1B: k = pos(3'd2, 3'd7);  // X
            7'h1C: k = pos(3'd3, 3'd1);  // Y
            7'h1D: k = pos(3'd1, 3'd4);  // Z
            7'h1E: k = pos(3'd7, 3'd0);  // 1
            7'h1F: k = pos(3'd7, 3'd3);  // 2
            7'h20: k = pos(3'd1, 3'd0);  // 3
            7'h21: k = pos(3'd1, 3'd3);  // 4
            7'h22: k = pos(3'd2, 3'd0);  // 5
            7'h23: k = pos(3'd2, 3'd3);  // 6
            7'h24: k = pos(3'd3, 3'd0);  // 7
            7'h25: k = pos(3'd3, 3'd3);  // 8
            7'h26: k = pos(3'd4, 3'd0);  // 9
            7'h27: k = pos(3'd4, 3'd3);  // 0
            7'h28: k = pos(3'd0, 3'd1);  // Enter -> RETURN
            7'h29: k = pos(3'd7, 3'd7);  // Esc -> RUN/STOP
            7'h2A: k = pos(3'd0, 3'd0);  // Backspace -> DEL
            7'h2B: k = pos(3'd7, 3'd2);  // Tab -> CTRL
            7'h2C: k = pos(3'd7, 3'd4);  // Space
            7'h2D: k = pos(3'd5, 3'd3);  // -
            7'h2E: k = pos(3'd6, 3'd5);  // =
            7'h2F: k = pos(3'd5, 3'd6);  // [ -> @
            7'h30: k = pos(3'd6, 3'd1);  // ] -> *
            7'h31: k = pos(3'd6, 3'd0);  // \ -> pound
            7'h33: k = pos(3'd6, 3'd2);  // ;
            7'h34: k = pos(3'd5, 3'd5);  // ' -> :
            7'h35: k = pos(3'd7, 3'd1);  // ` -> left arrow
            7'h36: k = pos(3'd5, 3'd7);  // ,
            7'h37: k = pos(3'd5, 3'd4);  // .
            7'h38: k = pos(3'd6, 3'd7);  // /
            7'h3A: k = pos(3'd0, 3'd4);  // F1
            7'h3C: k = pos(3'd0, 3'd5);  // F3
            7'h3E: k = pos(3'd0, 3'd6);  // F5
            7'h40: k = pos(3'd0, 3'd3);  // F7
            7'h49: k = pos(3'd5, 3'd0);  // Insert -> +
            7'h4A: k = pos(3'd6, 3'd3);  // Home
            7'h4D: k = pos(3'd6, 3'd6);  // End -> up arrow
            7'h4F: k = pos(3'd0, 3'd2);  // Right
            7'h51: k = pos(3'd0, 3'd7);  // Down
            7'h50: begin k = pos(3'd0, 3'd2); k.vleft = 1'b1; end  // Left
            7'h52: begin k = pos(3'd0, 3'd7); k.vup   = 1'b1; end  // Up
            7'h4B: k.rst = 1'b1;         // PageUp -> RESTORE
            7'h68: k = pos(3'd7, 3'd2);  // LCTRL
            7'h69: k = pos(3'd1, 3'd7);  // LSHIFT
            7'h6B: k = pos(3'd7, 3'd5);  // LGUI -> C=
            7'h6D: k = pos(3'd6, 3'd4);  // RSHIFT
`ifdef KBD_SHIFTLOCK_EN
            7'h39: k.lock = 1'b1;        // CapsLock -> shift-lock toggle
`endif
            default: k = '0;
        endcase
        return k;
    endfunction

    state_t      state, next_state;
    logic [7:0]  evt, last_evt;
    key_t        dec;
    logic [63:0] matrix;
    logic [63:0] eff;
    logic        vshift_up, vshift_left;
    logic [7:0]  scan_pb, scan_pa;
    logic        new_evt;
`ifdef KBD_SHIFTLOCK_EN
    logic        shiftlock;
`endif

    assign new_evt = (usb_kbd != last_evt);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (new_evt) next_state = DECODE;
            DECODE:  next_state = APPLY;
            APPLY:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == DECODE) || (state == APPLY);
    end

    // Capture a new event; comparing against last_evt catches changes made while busy
    always_ff @(posedge clk) begin
        if (reset) begin
            last_evt <= 8'h00;
        end else if (state == IDLE && new_evt) begin
            evt      <= usb_kbd;
            last_evt <= usb_kbd;
        end
    end

    // Keymap lookup registered during DECODE
    always_ff @(posedge clk) begin
        if (state == DECODE) dec <= lookup(evt[6:0]);
    end

    // Apply the decoded event to the held-key image; reset discards an in-flight event
    always_ff @(posedge clk) begin
        if (reset) begin
            matrix      <= '0;
            vshift_up   <= 1'b0;
            vshift_left <= 1'b0;
            restore     <= 1'b0;
`ifdef KBD_SHIFTLOCK_EN
            shiftlock   <= 1'b0;
`endif
        end else if (state == APPLY) begin
            if (dec.hit)   matrix[{dec.col, dec.row}] <= ~evt[7];
            if (dec.vup)   vshift_up   <= ~evt[7];
            if (dec.vleft) vshift_left <= ~evt[7];
            if (dec.rst)   restore     <= ~evt[7];
`ifdef KBD_SHIFTLOCK_EN
            if (dec.lock && !evt[7]) shiftlock <= ~shiftlock;
`endif
        end
    end

    // Effective image: LSHIFT (col1,row7) also held by the virtual shifts
    always_comb begin
        eff     = matrix;
`ifdef KBD_SHIFTLOCK_EN
        eff[15] = matrix[15] | vshift_up | vshift_left | shiftlock;
`else
        eff[15] = matrix[15] | vshift_up | vshift_left;
`endif
    end

    // Bidirectional scan, no ghost suppression
    always_comb begin
        scan_pb = 8'hFF;
        scan_pa = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                if (eff[c*8 + r]) begin
                    if (!pa_out[c]) scan_pb[r] = 1'b0;
                    if (!pb_out[r]) scan_pa[c] = 1'b0;
                end
            end
        end
    end

    generate
        if (SCAN_REG != 0) begin : g_scan_reg
            // Registered scan outputs, idle-high after reset
            always_ff @(posedge clk) begin
                if (reset) begin
                    pb_in <= 8'hFF;
                    pa_in <= 8'hFF;
                end else begin
                    pb_in <= scan_pb;
                    pa_in <= scan_pa;
                end
            end
        end else begin : g_scan_comb
            assign pb_in = scan_pb;
            assign pa_in = scan_pa;
        end
    endgenerate

endmodule
